nx_node_store_arbiter: RTL and testbench
========================================

Name: nx_node_store_arbiter

Overview:
Shares the node's single-port instruction/mapping store between several requesters: inbound loader writes, instruction fetch, input handling, and output message generation (lookup and mapping reads). Sits between the node control sub-blocks and the store RAM. It arbitrates one access per cycle, round-robin. A lock lets a requester hold the port for a burst, for example an output mapping stream. It returns read data to the winning requester one cycle later.

Parameters:
REQUESTERS, 4, number of requester ports (index 0 = loader)
RAM_ADDR_W, 10, store address width
RAM_DATA_W, 32, store data width
MAX_LOCK, 16, max consecutive granted cycles under lock before forced release (>=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-low (asserted when 0)
o_idle  out  1  no request pending, no lock held, no read in flight
i_req_addr  in  REQUESTERS*RAM_ADDR_W  per-requester address, requester r at [r*RAM_ADDR_W +: RAM_ADDR_W]
i_req_rd_en  in  REQUESTERS  read request
i_req_wr_en  in  REQUESTERS  write request
i_req_wr_data  in  REQUESTERS*RAM_DATA_W  write data
i_req_lock  in  REQUESTERS  keep grant after this access
o_req_gnt  out  REQUESTERS  one-hot grant, combinational, same cycle as access
o_req_rd_data  out  RAM_DATA_W  read data, broadcast to all requesters
o_req_rd_valid  out  REQUESTERS  one-hot, o_req_rd_data valid for that requester
o_err  out  1  sticky: a requester asserted rd_en and wr_en together
o_ram_addr  out  RAM_ADDR_W  store address
o_ram_rd_en  out  1  store read enable
o_ram_wr_en  out  1  store write enable
o_ram_wr_data  out  RAM_DATA_W  store write data
i_ram_rd_data  in  RAM_DATA_W  store read data, one-cycle latency

Behaviour:
- Request for requester r: rd_en[r] | wr_en[r].
- Grant is combinational from requests and state.
- RAM signals are the granted requester's signals muxed through. With no grant: all enables are 0 and the address holds its last value (registered copy).
- State machine, states ARB and LOCKED:
  - ARB: grant the first requesting index at or after rr_ptr, wrapping modulo REQUESTERS.
    - On a grant to g: rr_ptr <= g+1 (wrap to 0 past REQUESTERS-1).
    - If lock[g] is also set: owner <= g, lock_cnt <= 1, go to LOCKED.
  - LOCKED:
    - Only the owner can be granted, and only when it requests.
    - Owner idle (no request) with lock still high: grant none, port held, lock_cnt does not advance.
    - Owner drops lock: go to ARB the next cycle. An access made in the same cycle is still granted.
    - lock_cnt increments per granted owner cycle.
    - When lock_cnt reaches MAX_LOCK on a grant: forced return to ARB, and the owner is excluded from the following arbitration cycle if any other requester is pending.
- Read return:
  - rd_valid_q <= gnt & rd_en; o_req_rd_valid = rd_valid_q.
  - o_req_rd_data = i_ram_rd_data, passed through unregistered.
  - Latency from granted read to valid is exactly 1 cycle.
- Write: performed in the grant cycle; no response.
- rd_en & wr_en on the granted requester: the write is performed, the read is suppressed (no rd_valid), and o_err sets. o_err clears only on reset.
- A requester must hold its request until it sees gnt. Requests are not queued.
- Reset (i_rst=0, asynchronous):
  - State ARB, rr_ptr=0, owner=0, lock_cnt=0, rd_valid_q=0, o_err=0, registered address 0.
  - Outputs: o_req_gnt=0, o_ram_rd_en=0, o_ram_wr_en=0, o_idle=1.
  - Reset mid-lock or mid-read drops the lock and the in-flight valid.
- o_idle = (state==ARB) && !(|requests) && !(|rd_valid_q).
- REQUESTERS=1 degenerates to pass-through plus the lock counter.

Decomposition:
- NXConstants gains a store_arb_state_t enum (ARB, LOCKED).
- Sub-module nx_rr_arbiter (WIDTH parameter):
  - inputs: request vector, pointer, exclude mask
  - output: one-hot grant
  - purely combinational, reusable by the mesh router.
- Register declarations use the common DQ macro set. Those macros must support the active-low asynchronous reset.

Test Plan:
- Single read: r2 reads addr 0x05 with RAM content 0xDEADBEEF at 0x05 -> gnt=4'b0100 the same cycle; next cycle rd_valid=4'b0100 and rd_data=0xDEADBEEF.
- Round-robin: all four requesters read continuously from reset -> grants cycle 0,1,2,3,0 in order; no requester is granted twice within 4 cycles.
- Lock burst: r3 locks for 5 reads at 0x10..0x14 while r0 and r1 request -> r3 is granted 5 consecutive cycles; r0 is granted the cycle after r3 drops lock.
- Lock timeout: MAX_LOCK=4, r1 holds lock and reads every cycle, r2 pending -> r1 is granted 4 cycles, then r2 is granted, then r1 may be granted again.
- Conflict: r0 asserts rd_en and wr_en with addr 0x20, data 0x1234 -> RAM write of 0x1234 at 0x20; no rd_valid; o_err=1 until reset.
- Reset mid-lock: i_rst pulled to 0 asynchronously during a r3 lock with a read in flight -> gnt and rd_valid are 0 immediately; after release r0 wins the first contended arbitration.

Source files
------------

// File: rtl/nx_node_store_arbiter_pkg.sv
// Shared types for the node store arbiter and its round-robin helper.
package nx_node_store_arbiter_pkg;
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } store_arb_state_t;
endpackage

// File: rtl/nx_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after ptr_i.
module nx_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic [WIDTH-1:0] excl_i,
  output logic [WIDTH-1:0] gnt_o
);
  logic [WIDTH-1:0] cand;
  logic             found;
  int               idx;

  assign cand = req_i & ~excl_i;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = (int'(ptr_i) + i) % WIDTH;
      if (!found && cand[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/nx_node_store_arbiter.sv
// Single-port store arbiter: round-robin grant, lockable bursts with a hard
// cap, and one-cycle read return to the winning requester.
module nx_node_store_arbiter
  import nx_node_store_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_DATA_W = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  output logic                             o_idle,
  input  logic [REQUESTERS*RAM_ADDR_W-1:0] i_req_addr,
  input  logic [REQUESTERS-1:0]            i_req_rd_en,
  input  logic [REQUESTERS-1:0]            i_req_wr_en,
  input  logic [REQUESTERS*RAM_DATA_W-1:0] i_req_wr_data,
  input  logic [REQUESTERS-1:0]            i_req_lock,
  output logic [REQUESTERS-1:0]            o_req_gnt,
  output logic [RAM_DATA_W-1:0]            o_req_rd_data,
  output logic [REQUESTERS-1:0]            o_req_rd_valid,
  output logic                             o_err,
  output logic [RAM_ADDR_W-1:0]            o_ram_addr,
  output logic                             o_ram_rd_en,
  output logic                             o_ram_wr_en,
  output logic [RAM_DATA_W-1:0]            o_ram_wr_data,
  input  logic [RAM_DATA_W-1:0]            i_ram_rd_data
);
  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  store_arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]        lock_cnt_q, lock_cnt_d, cnt_inc;
  logic [REQUESTERS-1:0]   excl_q, excl_d, excl_eff;
  logic [REQUESTERS-1:0]   rd_valid_q, rd_valid_d;
  logic                    err_q, err_d;
  logic [RAM_ADDR_W-1:0]   addr_q, addr_d;

  logic [REQUESTERS-1:0]   req, arb_gnt, gnt;
  logic [PTR_W-1:0]        sel;
  logic                    any_gnt, sel_rd, sel_wr;

  assign req     = i_req_rd_en | i_req_wr_en;
  assign cnt_inc = lock_cnt_q + CNT_W'(1);

  // Exclusion after a forced release only bites if someone else is waiting.
  assign excl_eff = (|(req & ~excl_q)) ? excl_q : '0;

  nx_rr_arbiter #(.WIDTH(REQUESTERS), .PTR_W(PTR_W)) u_rr (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .excl_i (excl_eff),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    excl_d     = '0;
    gnt        = '0;
    sel        = '0;
    case (state_q)
      ARB: begin
        gnt = arb_gnt;
        for (int i = 0; i < REQUESTERS; i++)
          if (arb_gnt[i]) sel = PTR_W'(i);
        if (|arb_gnt) begin
          rr_ptr_d = (sel == PTR_W'(REQUESTERS - 1)) ? '0 : sel + PTR_W'(1);
          if (i_req_lock[sel]) begin
            owner_d    = sel;
            lock_cnt_d = CNT_W'(1);
            state_d    = LOCKED;
          end
        end
      end
      LOCKED: begin
        sel = owner_q;
        if (req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          lock_cnt_d   = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_LOCK)) begin
            state_d         = ARB;
            excl_d[owner_q] = 1'b1;
          end else if (!i_req_lock[owner_q]) begin
            state_d = ARB;
          end
        end else if (!i_req_lock[owner_q]) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Outputs are forced quiet while reset is held, even with requests present.
  assign o_req_gnt     = gnt & {REQUESTERS{i_rst}};
  assign any_gnt       = |o_req_gnt;
  assign sel_rd        = i_req_rd_en[sel];
  assign sel_wr        = i_req_wr_en[sel];
  assign o_ram_addr    = any_gnt ? i_req_addr[int'(sel)*RAM_ADDR_W +: RAM_ADDR_W] : addr_q;
  assign o_ram_wr_data = i_req_wr_data[int'(sel)*RAM_DATA_W +: RAM_DATA_W];
  assign o_ram_wr_en   = any_gnt & sel_wr;
  assign o_ram_rd_en   = any_gnt & sel_rd & ~sel_wr;

  assign addr_d     = o_ram_addr;
  assign rd_valid_d = o_ram_rd_en ? o_req_gnt : '0;
  assign err_d      = err_q | (any_gnt & sel_rd & sel_wr);

  assign o_req_rd_valid = rd_valid_q;
  assign o_req_rd_data  = i_ram_rd_data;
  assign o_err          = err_q;
  assign o_idle         = !i_rst || ((state_q == ARB) && !(|req) && !(|rd_valid_q));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      excl_q     <= '0;
      rd_valid_q <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      excl_q     <= excl_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
    end
  end
endmodule

// File: tb/tb_nx_node_store_arbiter.sv
// Directed bench: default DUT with a behavioural store, plus a MAX_LOCK=4 copy for the timeout case.
module tb_nx_node_store_arbiter;
  localparam int R = 4, AW = 10, DW = 32;

  logic clk = 1'b0, rst = 1'b0;
  logic [R*AW-1:0] addr;
  logic [R-1:0]    rd, wr, lk;
  logic [R*DW-1:0] wd;

  logic          idle, err, ram_rd, ram_wr;
  logic [R-1:0]  gnt, rvld;
  logic [DW-1:0] rdata, ram_wd, ram_q;
  logic [AW-1:0] ram_a;

  logic          idle4, err4, ram_rd4, ram_wr4;
  logic [R-1:0]  gnt4, rvld4;
  logic [DW-1:0] rdata4, ram_wd4;
  logic [AW-1:0] ram_a4;
  logic [DW-1:0] zero_d = '0;

  logic [DW-1:0] mem [0:1023];
  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_a] <= ram_wd;
    if (ram_rd) ram_q <= mem[ram_a];
  end

  nx_node_store_arbiter dut (
    .i_clk(clk), .i_rst(rst), .o_idle(idle), .i_req_addr(addr), .i_req_rd_en(rd),
    .i_req_wr_en(wr), .i_req_wr_data(wd), .i_req_lock(lk), .o_req_gnt(gnt),
    .o_req_rd_data(rdata), .o_req_rd_valid(rvld), .o_err(err), .o_ram_addr(ram_a),
    .o_ram_rd_en(ram_rd), .o_ram_wr_en(ram_wr), .o_ram_wr_data(ram_wd), .i_ram_rd_data(ram_q));

  nx_node_store_arbiter #(.MAX_LOCK(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .o_idle(idle4), .i_req_addr(addr), .i_req_rd_en(rd),
    .i_req_wr_en(wr), .i_req_wr_data(wd), .i_req_lock(lk), .o_req_gnt(gnt4),
    .o_req_rd_data(rdata4), .o_req_rd_valid(rvld4), .o_err(err4), .o_ram_addr(ram_a4),
    .o_ram_rd_en(ram_rd4), .o_ram_wr_en(ram_wr4), .o_ram_wr_data(ram_wd4), .i_ram_rd_data(zero_d));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setr(input int r, input bit r_rd, input bit r_wr, input bit r_lk,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd[r] = r_rd; wr[r] = r_wr; lk[r] = r_lk;
    addr[r*AW +: AW] = a;
    wd[r*DW +: DW] = d;
  endtask

  task automatic clr();
    rd = '0; wr = '0; lk = '0; addr = '0; wd = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b0; #1; rst = 1'b1;
  endtask

  initial begin
    logic [R-1:0] rr_exp [0:4];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h05] = 32'hDEADBEEF;
    mem[10'h14] = 32'hA5A50014;
    clr();
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    chk("rst_rvld", rvld, 0);
    chk("rst_ram_en", {ram_rd, ram_wr}, 0);
    chk("rst_ram_addr", ram_a, 0);
    #1 rst = 1'b1;

    // single read
    step(); setr(2, 1, 0, 0, 10'h05, 0); #1;
    chk("rd_gnt", gnt, 4'b0100);
    chk("rd_ram_addr", ram_a, 10'h05);
    chk("rd_ram_rd", ram_rd, 1);
    step(); clr(); #1;
    chk("rd_vld", rvld, 4'b0100);
    chk("rd_data", rdata, 32'hDEADBEEF);
    chk("rd_gnt_off", gnt, 0);
    chk("rd_addr_hold", ram_a, 10'h05);
    step(); #1;
    chk("rd_idle", idle, 1);

    // round robin from reset
    pulse_rst();
    for (int r = 0; r < R; r++) setr(r, 1, 0, 0, AW'(r), 0);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("rr_gnt", gnt, rr_exp[c]);
      if (c > 0) chk("rr_vld", rvld, rr_exp[c-1]);
      step(); #1;
    end
    clr();

    // lock burst: r3 alone first, then r0/r1 contend
    step(); setr(3, 1, 0, 1, 10'h10, 0); #1;
    chk("lk_gnt0", gnt, 4'b1000);
    for (int k = 1; k < 5; k++) begin
      step();
      setr(0, 1, 0, 0, 10'h01, 0);
      setr(1, 1, 0, 0, 10'h02, 0);
      setr(3, 1, 0, (k < 4), AW'(10'h10 + k), 0);
      #1;
      chk("lk_gnt", gnt, 4'b1000);
      chk("lk_addr", ram_a, AW'(10'h10 + k));
    end
    step(); setr(3, 0, 0, 0, 0, 0); #1;
    chk("lk_after", gnt, 4'b0001);
    chk("lk_last_vld", rvld, 4'b1000);
    chk("lk_last_data", rdata, 32'hA5A50014);
    step(); clr(); #1;

    // lock timeout on MAX_LOCK=4 instance
    pulse_rst();
    setr(1, 1, 0, 1, 10'h30, 0);
    setr(2, 1, 0, 0, 10'h31, 0);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("to_r1", gnt4, 4'b0010);
      step(); #1;
    end
    chk("to_r2", gnt4, 4'b0100);
    step(); setr(2, 0, 0, 0, 0, 0); #1;
    chk("to_r1_again", gnt4, 4'b0010);
    step(); clr(); #1;
    step(); #1;
    chk("to_idle4", idle4, 1);

    // rd+wr conflict
    step(); setr(0, 1, 1, 0, 10'h20, 32'h1234); #1;
    chk("cf_gnt", gnt, 4'b0001);
    chk("cf_wr", {ram_wr, ram_rd}, 2'b10);
    chk("cf_wd", ram_wd, 32'h1234);
    chk("cf_addr", ram_a, 10'h20);
    step(); clr(); #1;
    chk("cf_vld", rvld, 0);
    chk("cf_err", err, 1);
    chk("cf_mem", mem[10'h20], 32'h1234);
    step(); step(); #1;
    chk("cf_err_sticky", err, 1);

    // reset mid-lock with read in flight
    step(); setr(3, 1, 0, 1, 10'h05, 0); #1;
    chk("rm_gnt0", gnt, 4'b1000);
    step(); #1;
    chk("rm_gnt1", gnt, 4'b1000);
    chk("rm_vld", rvld, 4'b1000);
    chk("rm_busy", idle, 0);
    #1 rst = 1'b0; #1;
    chk("rm_gnt_rst", gnt, 0);
    chk("rm_vld_rst", rvld, 0);
    chk("rm_idle_rst", idle, 1);
    chk("rm_err_rst", err, 0);
    setr(0, 1, 0, 0, 10'h07, 0);
    #1 rst = 1'b1; #1;
    chk("rm_r0_wins", gnt, 4'b0001);
    step(); clr(); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
